// File: rtl/params_noc.sv
// Shared NoC router constants: port enumeration and virtual-channel sizing.
package params_noc;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } inout_Port;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_Size  = $clog2(VC_NUM);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int N = 10,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int   pos_s;
    logic found_s;

    // scan N positions starting at the pointer, keep the first hit
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < N; i++) begin
            pos_s = (int'(ptr_i) + i) % N;
            if (!found_s && req_i[pos_s]) begin
                found_s      = 1'b1;
                gnt_o[pos_s] = 1'b1;
                idx_o        = pos_s[W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/vc_allocator.sv
// Router VC allocator: per-output-port round-robin over input VCs, hands out the
// lowest free downstream VC and tracks ownership until the VC is released.
module vc_allocator
    import params_noc::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_NUM*VC_NUM-1:0] vc_req_i,
    input  inout_Port                  out_port_i [PORT_NUM*VC_NUM],
    input  logic [PORT_NUM*VC_NUM-1:0] vc_release_i,
    output logic [PORT_NUM*VC_NUM-1:0] vc_val_o,
    output logic [VC_Size-1:0]         vc_new_o [PORT_NUM*VC_NUM],
    output logic [PORT_NUM*VC_NUM-1:0] vc_busy_o,
    output logic                       err_o
);

    localparam int REQ_NUM = PORT_NUM * VC_NUM;
    localparam int IDX_W   = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0] busy_q, busy_d;
    logic [REQ_NUM-1:0] val_q, val_d;
    logic [VC_Size-1:0] new_q [REQ_NUM];
    logic [VC_Size-1:0] new_d [REQ_NUM];
    logic               err_q, err_d;
    logic [IDX_W-1:0]   ptr_q [PORT_NUM];
    logic [IDX_W-1:0]   ptr_d [PORT_NUM];

    logic [REQ_NUM-1:0]  req_ok_s, bad_req_s;
    logic [REQ_NUM-1:0]  elig_s [PORT_NUM];
    logic [REQ_NUM-1:0]  gnt_s  [PORT_NUM];
    logic [IDX_W-1:0]    win_s  [PORT_NUM];
    logic [PORT_NUM-1:0] any_s;
    logic [PORT_NUM-1:0] free_any_s;
    logic [VC_Size-1:0]  free_idx_s [PORT_NUM];

    // qualify requests and find the lowest free downstream VC of each port
    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            bad_req_s[r] = vc_req_i[r] && (int'(out_port_i[r]) >= PORT_NUM);
            // a requester already holding a grant pulse is masked for this cycle
            req_ok_s[r]  = vc_req_i[r] && !bad_req_s[r] && !val_q[r];
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            free_any_s[p] = |(~busy_q[p*VC_NUM +: VC_NUM]);
            free_idx_s[p] = '0;
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                free_idx_s[p] = busy_q[p*VC_NUM + v] ? free_idx_s[p] : VC_Size'(v);
            end
            for (int r = 0; r < REQ_NUM; r++) begin
                elig_s[p][r] = req_ok_s[r] && (int'(out_port_i[r]) == p) && free_any_s[p];
            end
        end
    end

    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_arb
        rr_arbiter #(.N(REQ_NUM)) u_arb (
            .req_i (elig_s[gp]),
            .ptr_i (ptr_q[gp]),
            .gnt_o (gnt_s[gp]),
            .idx_o (win_s[gp]),
            .any_o (any_s[gp])
        );
    end

    // next-state: releases, grants, pointer advance and error detection
    always_comb begin
        // releasing an idle VC leaves its bit at 0, so the bad release is ignored
        busy_d = busy_q & ~vc_release_i;
        err_d  = (|(vc_release_i & ~busy_q)) || (|bad_req_s);
        val_d  = '0;
        for (int r = 0; r < REQ_NUM; r++) begin
            new_d[r] = '0;
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            ptr_d[p] = ptr_q[p];
            if (any_s[p]) begin
                val_d                                   = val_d | gnt_s[p];
                new_d[win_s[p]]                         = free_idx_s[p];
                busy_d[p*VC_NUM + int'(free_idx_s[p])]  = 1'b1;
                ptr_d[p] = (int'(win_s[p]) == REQ_NUM - 1) ? '0 : win_s[p] + IDX_W'(1);
            end else begin
                ptr_d[p] = ptr_q[p];
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            val_q  <= '0;
            err_q  <= 1'b0;
            for (int r = 0; r < REQ_NUM; r++) begin
                new_q[r] <= '0;
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                ptr_q[p] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            val_q  <= val_d;
            err_q  <= err_d;
            for (int r = 0; r < REQ_NUM; r++) begin
                new_q[r] <= new_d[r];
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                ptr_q[p] <= ptr_d[p];
            end
        end
    end

    assign vc_busy_o = busy_q;
    assign vc_val_o  = val_q;
    assign vc_new_o  = new_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Directed scoreboard bench for vc_allocator: expected grant/error events are queued
// with the stimulus and a negedge monitor checks each output event against them.
module tb_vc_allocator;
    import params_noc::*;

    localparam int RN = PORT_NUM * VC_NUM;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RN-1:0]     vc_req_i, vc_release_i, vc_val_o, vc_busy_o;
    inout_Port         out_port_i [RN];
    logic [VC_Size-1:0] vc_new_o [RN];
    logic              err_o;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [RN-1:0] val;
        logic [RN-1:0] nw;
        logic          err;
        logic [RN-1:0] busy;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    vc_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vc_req_i     (vc_req_i),
        .out_port_i   (out_port_i),
        .vc_release_i (vc_release_i),
        .vc_val_o     (vc_val_o),
        .vc_new_o     (vc_new_o),
        .vc_busy_o    (vc_busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [RN-1:0] pack_new();
        logic [RN-1:0] p;
        p = '0;
        for (int r = 0; r < RN; r++) p[r] = vc_new_o[r][0];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [RN-1:0] v, input logic [RN-1:0] nw,
                             input logic e, input logic [RN-1:0] b);
        exp_q.push_back('{val: v, nw: nw, err: e, busy: b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [RN-1:0] req, input logic [RN-1:0] rel);
        vc_req_i     = req;
        vc_release_i = rel;
        tick();
    endtask

    // monitor: every grant or error pulse must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && ((|vc_val_o) || err_o)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: actual val=%h err=%b required no event",
                         vc_val_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant_val", 32'(vc_val_o),   32'(mon_e.val));
                chk("grant_vc",  32'(pack_new()), 32'(mon_e.nw));
                chk("err",       32'(err_o),      32'(mon_e.err));
                chk("busy",      32'(vc_busy_o),  32'(mon_e.busy));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        vc_req_i     = '0;
        vc_release_i = '0;
        for (int r = 0; r < RN; r++) out_port_i[r] = LOCAL;
        #3;
        chk("reset_val",  32'(vc_val_o),   32'h0);
        chk("reset_busy", 32'(vc_busy_o),  32'h0);
        chk("reset_err",  32'(err_o),      32'h0);
        chk("reset_new",  32'(pack_new()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single request LOCAL vc0 -> EAST, then release it
        out_port_i[0] = EAST;
        expect_ev(10'h001, 10'h000, 1'b0, 10'h040);
        drive(10'h001, 10'h000);
        drive(10'h000, 10'h040);
        drive(10'h000, 10'h000);

        // 2, 4, 6 contend for NORTH; 6 waits for a release
        out_port_i[2] = NORTH;
        out_port_i[4] = NORTH;
        out_port_i[6] = NORTH;
        expect_ev(10'h004, 10'h000, 1'b0, 10'h004);
        drive(10'h054, 10'h000);
        expect_ev(10'h010, 10'h010, 1'b0, 10'h00C);
        drive(10'h050, 10'h000);
        drive(10'h040, 10'h000);
        drive(10'h040, 10'h000);
        drive(10'h040, 10'h000);
        drive(10'h040, 10'h004);
        expect_ev(10'h040, 10'h000, 1'b0, 10'h00C);
        drive(10'h040, 10'h000);
        drive(10'h000, 10'h000);

        // release NORTH vc1 together with a new NORTH request
        out_port_i[0] = NORTH;
        drive(10'h001, 10'h008);
        expect_ev(10'h001, 10'h001, 1'b0, 10'h00C);
        drive(10'h001, 10'h000);
        drive(10'h000, 10'h00C);
        drive(10'h000, 10'h000);

        // requesters 1 and 3 share WEST with a release after every grant
        out_port_i[1] = WEST;
        out_port_i[3] = WEST;
        for (int k = 0; k < 20; k++) begin
            logic [RN-1:0] req;
            logic [RN-1:0] rel;
            if (k == 0) begin
                req = 10'h00A;
                rel = 10'h000;
            end else if (k % 2 == 1) begin
                req = 10'h008;
                rel = 10'h100;
            end else begin
                req = 10'h002;
                rel = 10'h200;
            end
            if (k % 2 == 0) expect_ev(10'h002, 10'h000, 1'b0, 10'h100);
            else            expect_ev(10'h008, 10'h008, 1'b0, 10'h200);
            drive(req, rel);
        end
        drive(10'h000, 10'h200);
        drive(10'h000, 10'h000);

        // protocol errors: idle release, then out-of-range port
        expect_ev(10'h000, 10'h000, 1'b1, 10'h000);
        drive(10'h000, 10'h010);
        out_port_i[5] = inout_Port'(3'd7);
        expect_ev(10'h000, 10'h000, 1'b1, 10'h000);
        drive(10'h020, 10'h000);
        drive(10'h000, 10'h000);
        drive(10'h000, 10'h000);

        // three ports grant in one cycle, then reset with a grant pending
        out_port_i[0] = LOCAL;
        out_port_i[2] = SOUTH;
        out_port_i[4] = EAST;
        expect_ev(10'h015, 10'h000, 1'b0, 10'h051);
        drive(10'h015, 10'h000);
        out_port_i[6] = EAST;
        vc_req_i = 10'h040;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_val",  32'(vc_val_o),   32'h0);
        chk("async_reset_busy", 32'(vc_busy_o),  32'h0);
        chk("async_reset_err",  32'(err_o),      32'h0);
        chk("async_reset_new",  32'(pack_new()), 32'h0);
        out_port_i[2] = LOCAL;
        vc_req_i = 10'h045;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_ev(10'h041, 10'h000, 1'b0, 10'h041);
        tick();
        expect_ev(10'h004, 10'h004, 1'b0, 10'h043);
        drive(10'h004, 10'h000);
        drive(10'h000, 10'h000);
        drive(10'h000, 10'h000);
        drive(10'h000, 10'h000);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
